// File: rtl/fpga_ram_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpga_ram_reader_pkg;

    // Reader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Registered read latency of the RAM read port, in cycles
    localparam int RAM_RD_LATENCY = 1;

    // Upper bound on reads issued but not yet pushed into the output FIFO
    localparam int MAX_INFLIGHT = 2;

endpackage

// File: rtl/fpga_ram_reader_fifo.sv
// Single-clock FIFO carrying stream words plus the last tag.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; head is stable until popped.
module fpga_ram_reader_fifo #(
    parameter int width_p = 1,
    parameter int depth_p = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [width_p-1:0]         push_dat,
    input  logic                       pop_rdy,
    output logic [width_p-1:0]         pop_dat,
    output logic [$clog2(depth_p):0]   count,
    output logic                       full,
    output logic                       empty
);

    localparam int ptr_w_lp = $clog2(depth_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;

    logic [width_p-1:0]  mem [depth_p];
    logic [ptr_w_lp-1:0] wr_ptr;
    logic [ptr_w_lp-1:0] rd_ptr;
    logic [cnt_w_lp-1:0] cnt_q;
    logic                do_push;
    logic                do_pop;

    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign full    = (cnt_q == cnt_w_lp'(depth_p));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    // Head forced to zero when empty so the stream port idles at a known value
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    // Storage array: no reset needed, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fpga_ram_stream_reader.sv
// Burst read engine: takes (address, length) commands and streams RAM words out with a last flag.
// Latency: first beat on m_valid 3 cycles after the command handshake, then one word per cycle.
// Backpressure: reads are credited against FIFO space so m_ready may stall freely; optional
// burst counter enabled by FPGA_RAM_STREAM_READER_STATS_EN.
module fpga_ram_stream_reader
    import fpga_ram_reader_pkg::*;
#(
    parameter int data_width_p    = -1,
    parameter int address_width_p = -1,
    parameter int fifo_depth_p    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [address_width_p-1:0] cmd_address,
    input  logic [address_width_p-1:0] cmd_length,
    output logic [address_width_p-1:0] ram_rd_address,
    input  logic [data_width_p-1:0]    ram_rd_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [data_width_p-1:0]    m_data,
    output logic                       m_last,
`ifdef FPGA_RAM_STREAM_READER_STATS_EN
    output logic [31:0]                sr_burst_count,
`endif
    output logic                       busy
);

    localparam int cnt_w_lp = $clog2(fifo_depth_p) + 1;
    localparam int inf_w_lp = $clog2(MAX_INFLIGHT + 1);

    rd_state_e                  state_q;
    rd_state_e                  state_d;
    logic [address_width_p-1:0] addr_q;
    logic [address_width_p-1:0] remaining_q;
    logic                       issue;
    logic                       issue_q;
    logic                       last_q;
    logic                       last_issue;
    logic                       cmd_fire;
    logic                       credit_ok;
    logic [inf_w_lp-1:0]        inflight;
    logic [cnt_w_lp-1:0]        fifo_count;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [data_width_p:0]      fifo_head;

    // A read issued this cycle lands in the FIFO next cycle; issue_q marks that landing slot
    assign inflight   = {{(inf_w_lp-1){1'b0}}, issue_q};
    assign credit_ok  = (int'(fifo_count) + int'(inflight)) < fifo_depth_p;
    assign last_issue = (remaining_q == '0);
    assign cmd_fire   = cmd_valid && cmd_ready;

    assign ram_rd_address = addr_q;
    assign m_valid        = !fifo_empty;
    assign {m_last, m_data} = fifo_head;
    assign busy           = (state_q != ST_IDLE) || !fifo_empty;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: the last address issued moves to drain; drain ends once nothing is left
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_fire)              state_d = ST_READ;
            ST_READ:  if (issue && last_issue)   state_d = ST_DRAIN;
            ST_DRAIN: if (!issue_q && fifo_empty) state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: accept commands only when idle and out of reset, issue reads while credit allows
    always_comb begin
        cmd_ready = 1'b0;
        issue     = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = rst_n;
            ST_READ: issue     = credit_ok && !fifo_full;
            default: begin
                cmd_ready = 1'b0;
                issue     = 1'b0;
            end
        endcase
    end

    // Address/length bookkeeping and the one-stage tag pipe that tracks the RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            issue_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_q      <= cmd_address;
                remaining_q <= cmd_length;
            end else if (issue) begin
                addr_q <= addr_q + 1'b1;
                if (!last_issue) begin
                    remaining_q <= remaining_q - 1'b1;
                end
            end
            issue_q <= issue;
            last_q  <= issue && last_issue;
        end
    end

    fpga_ram_reader_fifo #(
        .width_p (data_width_p + 1),
        .depth_p (fifo_depth_p)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (issue_q),
        .push_dat ({last_q, ram_rd_data}),
        .pop_rdy  (m_ready),
        .pop_dat  (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef FPGA_RAM_STREAM_READER_STATS_EN
    // Count completed bursts (handshaken last beats), wrapping at 2**32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_burst_count <= '0;
        end else if (m_valid && m_ready && m_last) begin
            sr_burst_count <= sr_burst_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fpga_ram_stream_reader.sv
// Directed bench for fpga_ram_stream_reader on a 16-word RAM model.
// Latency: checks the 3-cycle first beat and back-to-back streaming.
// Backpressure: random m_ready with hold-stability and occupancy checks.
module tb_fpga_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FD = 4;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_address;
    logic [AW-1:0] cmd_length;
    logic [AW-1:0] ram_rd_address;
    logic [DW-1:0] ram_rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
`ifdef FPGA_RAM_STREAM_READER_STATS_EN
    logic [31:0]   sr_burst_count;
`endif

    int checks = 0;
    int errors = 0;
    int maxcnt = 0;

    logic [DW-1:0] ram [16];

    fpga_ram_stream_reader #(
        .data_width_p    (DW),
        .address_width_p (AW),
        .fifo_depth_p    (FD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_address    (cmd_address),
        .cmd_length     (cmd_length),
        .ram_rd_address (ram_rd_address),
        .ram_rd_data    (ram_rd_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
`ifdef FPGA_RAM_STREAM_READER_STATS_EN
        .sr_burst_count (sr_burst_count),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port with one cycle of registered latency
    always @(posedge clk) ram_rd_data <= ram[ram_rd_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command and return at the first cycle after its handshake
    task automatic issue_cmd(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] len);
        for (int i = 0; i < 50 && !cmd_ready; i++) step();
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_address = a;
        cmd_length  = len;
        step();
        cmd_valid   = 1'b0;
    endtask

    // Run one burst and check every beat against the RAM contents
    task automatic run_burst(input string tag, input int a, input int len, input bit bp);
        int n;
        int first;
        int lastc;
        bit hold;
        logic [DW-1:0] hold_dat;
        logic hold_last;
        n = 0; first = 0; lastc = 0; hold = 1'b0; hold_dat = '0; hold_last = 1'b0;
        issue_cmd(tag, AW'(a), AW'(len));
        for (int cyc = 0; cyc < 400 && n <= len; cyc++) begin
            m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold)
                chk({tag, "_hold"}, {23'd0, m_valid, m_last, m_data}, {23'd0, 1'b1, hold_last, hold_dat});
            if (m_valid && m_ready) begin
                chk({tag, "_data"}, 32'(m_data), 32'(8'hA0 | DW'((a + n) % 16)));
                chk({tag, "_last"}, 32'(m_last), 32'(n == len));
                if (n == 0) first = cyc;
                lastc = cyc;
                n++;
            end
            hold      = m_valid && !m_ready;
            hold_dat  = m_data;
            hold_last = m_last;
            if (int'(dut.u_fifo.count) > maxcnt) maxcnt = int'(dut.u_fifo.count);
            step();
        end
        m_ready = 1'b1;
        chk({tag, "_beats"}, 32'(n), 32'(len + 1));
        if (!bp) chk({tag, "_span"}, 32'(lastc - first), 32'(len));
    endtask

    initial begin
        int beats;
        bit acc;
        int extra;
        for (int i = 0; i < 16; i++) ram[i] = 8'hA0 | 8'(i);
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_address = '0; cmd_length = '0; m_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_m_valid",   32'(m_valid),   32'd0);
        chk("rst_m_last",    32'(m_last),    32'd0);
        chk("rst_m_data",    32'(m_data),    32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_rd_addr",   32'(ram_rd_address), 32'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single word: exact 3-cycle latency
        m_ready = 1'b1;
        issue_cmd("single", 4'h5, 4'h0);
        chk("single_rd_addr", 32'(ram_rd_address), 32'h5);
        chk("single_c1_vld",  32'(m_valid), 32'd0);
        step();
        chk("single_c2_vld",  32'(m_valid), 32'd0);
        step();
        chk("single_c3_vld",  32'(m_valid), 32'd1);
        chk("single_data",    32'(m_data),  32'hA5);
        chk("single_last",    32'(m_last),  32'd1);
        chk("single_busy_rdy", 32'(cmd_ready), 32'd0);
        step();
        chk("single_after_vld", 32'(m_valid), 32'd0);
        for (int i = 0; i < 5 && !cmd_ready; i++) step();
        chk("single_ready_back", 32'(cmd_ready), 32'd1);
        chk("single_idle_busy",  32'(busy), 32'd0);

        // Streaming: 8 back-to-back beats
        run_burst("stream", 8, 7, 1'b0);

        // Backpressure over the whole RAM, starting near the wrap point
        maxcnt = 0;
        run_burst("bp", 10, 15, 1'b1);
        chk("bp_max_count_ok", 32'(maxcnt <= FD), 32'd1);

        // Address wrap: 14, 15, 0, 1
        run_burst("wrap", 14, 3, 1'b0);

        // Command while busy is held off until the first burst drains
        m_ready = 1'b1;
        issue_cmd("busy1", 4'h0, 4'h3);
        cmd_valid = 1'b1; cmd_address = 4'h5; cmd_length = 4'h0;
        chk("busy_hold_rdy", 32'(cmd_ready), 32'd0);
        beats = 0; acc = 1'b0;
        for (int c = 0; c < 60 && !acc; c++) begin
            if (m_valid && m_ready) begin
                chk("busy1_data", 32'(m_data), 32'(8'hA0 | 8'(beats)));
                beats++;
            end
            if (cmd_ready) acc = 1'b1;
            else step();
        end
        chk("busy_accepted", 32'(acc), 32'd1);
        chk("busy_beats_before_accept", 32'(beats), 32'd4);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && !m_valid; i++) step();
        chk("busy2_vld",  32'(m_valid), 32'd1);
        chk("busy2_data", 32'(m_data),  32'hA5);
        chk("busy2_last", 32'(m_last),  32'd1);
        step();
        for (int i = 0; i < 5 && !cmd_ready; i++) step();

        // Reset after 2 of 8 beats aborts the burst
        issue_cmd("abort", 4'h0, 4'h7);
        step(); step();
        chk("abort_first_vld", 32'(m_valid), 32'd1);
        step(); step();
        chk("abort_third_data", 32'(m_data), 32'hA2);
        rst_n = 1'b0;
        #1;
        chk("abort_vld",  32'(m_valid),   32'd0);
        chk("abort_busy", 32'(busy),      32'd0);
        chk("abort_rdy",  32'(cmd_ready), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        run_burst("after_rst", 0, 0, 1'b0);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_valid) extra++;
            step();
        end
        chk("after_rst_no_extra", 32'(extra), 32'd0);

`ifdef FPGA_RAM_STREAM_READER_STATS_EN
        chk("stats_bursts", sr_burst_count, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpga_ram_stream_reader.md
Name: fpga_ram_stream_reader

Overview:
Read-side engine for the dual-clock 1W/1R block RAM.
- Accepts a burst command (start address, length) over a valid/ready handshake.
- Drives the RAM read-port address and absorbs the RAM's 1-cycle registered read latency.
- Streams the words out on a valid/ready/last interface with full backpressure.
- Sits in the RAM's read-clock domain, opposite the writer on port A.

Parameters:
data_width_p, -1, RAM/stream word width; must be overridden.
address_width_p, -1, RAM address width; depth = 2**address_width_p; must be overridden.
fifo_depth_p, 4, output buffer depth; power of two, ≥4 for full throughput.

Ports:
clk  in  1  block clock (RAM read-port clock)
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  engine idle, command accepted on valid&ready
cmd_address  in  address_width_p  first word address
cmd_length  in  address_width_p  words minus one (0 = 1 word, max = whole RAM)
ram_rd_address  out  address_width_p  to RAM port_b_address
ram_rd_data  in  data_width_p  from RAM port_b_data_out (valid 1 cycle after address)
m_valid  out  1  stream data valid
m_ready  in  1  stream sink ready
m_data  out  data_width_p  stream word
m_last  out  1  final word of burst
busy  out  1  burst in progress (not IDLE or FIFO non-empty)

Behaviour:
- Reset values: cmd_ready=0 while rst_n low, then 1. ram_rd_address=0, m_valid=0, m_last=0, m_data=0, busy=0. FIFO is emptied and the FSM goes to IDLE.
- Reset mid-burst aborts immediately. In-flight reads are discarded and no partial beats appear after release.
- FSM has three states:
  - IDLE: cmd_ready=1. On cmd_valid, latch address and remaining=cmd_length, go to READ.
  - READ: issue one read per cycle while credit allows. When the last address is issued, go to DRAIN.
  - DRAIN: wait until the in-flight pipe and FIFO are empty (last beat handshaken), then go to IDLE.
- Credit rule: issue a read only when fifo_count + inflight < fifo_depth_p. inflight is the number of reads issued but not yet written into the FIFO, at most 2. The FIFO must never overflow.
- Pipeline: a read issued in cycle c (ram_rd_address driven) returns ram_rd_data in cycle c+1. That data is written into the FIFO at the end of c+1 and is visible on m_valid from c+2.
- First-beat latency: 3 cycles from command handshake to m_valid (with m_ready high).
- Throughput: one word per cycle sustained when m_ready is held high.
- Address arithmetic: increments modulo 2**address_width_p. It wraps from depth-1 to 0 silently.
- m_last is carried through the FIFO as a tag bit. It is set only on the word whose remaining count was 0 at issue.
- Handshake: once m_valid is asserted, m_data, m_last and m_valid stay stable until m_ready. A beat transfers on m_valid&m_ready.
- Simultaneous FIFO push and pop in the same cycle: count is unchanged.
- cmd_valid while busy: held off (cmd_ready=0). No queuing.
- cmd_length = 2**address_width_p-1: reads the whole RAM starting and ending around the wrap point.
- No write-collision handling here. Writers must not overwrite the active burst range.

Optional Feature:
Macro FPGA_RAM_STREAM_READER_STATS_EN.
- Defined: adds output sr_burst_count [31:0], reset 0. It increments by 1 on each m_last handshake and wraps at 2**32.
- Not defined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package fpga_ram_reader_pkg holds:
  - FSM state enum (IDLE, READ, DRAIN), 2 bits.
  - Constant for the RAM read latency (1).
  - Constant for the max inflight count (2).
- Sub-module fpga_ram_reader_fifo: single-clock synchronous FIFO of width data_width_p+1 (data plus last tag), depth fifo_depth_p.
  - Outputs count, full and empty.
  - Its read side drives m_valid/m_data/m_last directly.

Test Plan:
- Single word: cmd addr 0x05, len 0, RAM[5]=0xA5, m_ready=1 -> m_valid 3 cycles after accept, m_data=0xA5, m_last=1, cmd_ready back high after the beat.
- Streaming: addr 0x10, len 7, m_ready=1 -> 8 consecutive beats, one per cycle, data RAM[0x10..0x17], m_last only on the 8th.
- Backpressure: len 15, m_ready toggled pseudo-randomly -> all 16 words delivered in order with no drop or duplicate, and fifo_count never exceeds fifo_depth_p.
- Wrap: address_width_p=4, addr 0xE, len 3 -> words RAM[14], RAM[15], RAM[0], RAM[1].
- Reset mid-burst: rst_n low after 2 of 8 beats -> m_valid=0 immediately. After release, a new cmd (addr 0, len 0) returns only RAM[0].
- Command while busy: cmd_valid during a burst -> cmd_ready=0 until DRAIN completes, then the command is accepted.
